io_bus_arbiter: RTL
===================

# io_bus_arbiter

Two-port arbiter and access sequencer for the memory-mapped IO bus (LED number register, LED register, switch input, data memory). It shares the single bus between the CPU data port (port 0) and a secondary master such as a program loader or debug port (port 1). It uses round-robin priority and fixed, parameterised wait states. It sits between the requesters and the IO bus, and it owns the bus write strobe.

## Interface
- WAIT_CYCLES, 1, bus access cycles per transaction (legal range 1..15); read data is captured on the last one.
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  port request; held high until that port's ack.
- we0 / we1  in  1  port write enable; 0 = read.
- adr0 / adr1  in  14  port word address [15:2].
- wdata0 / wdata1  in  32  port write data.
- gnt0 / gnt1  out  1  port owns the bus; high from the first ACCESS cycle through DONE.
- ack0 / ack1  out  1  one-cycle pulse in DONE; rdata is valid in the same cycle.
- rdata  out  32  registered read data; holds its value until the next capture.
- busy  out  1  state != IDLE.
- bus_we  out  1  bus write strobe.
- bus_adr  out  14  bus word address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data (combinational from the IO bus).

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner. A lone request wins. If both ports request, the port not served last wins.
  - Latch the winner's we, adr and wdata into the bus registers. Load wait_cnt = WAIT_CYCLES-1. Update last. Go to ACCESS.
- ACCESS:
  - bus_we = latched we in the first ACCESS cycle only, so each write produces exactly one strobe.
  - Bus address and data stay stable for the whole state.
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0: rdata <= bus_rdata (reads only; unchanged on writes), then go to DONE.
- DONE: ack of the owner = 1, then go to IDLE. Requests are not evaluated in DONE.
- last register: 1 bit, reset value 1, so port 0 wins the first contention.
- A requester that drops req mid-transaction does not abort the transaction. It completes and the ack still pulses.
- Request inputs are sampled only in IDLE. Changes during ACCESS and DONE are ignored.
- Reset values (asserted asynchronously):
  - State = IDLE.
  - gnt0/1, ack0/1, busy, bus_we = 0.
  - bus_adr, bus_wdata, rdata = 0.
  - wait_cnt = 0, last = 1.
  - A reset during ACCESS suppresses the write strobe and the ack. No partial ack is ever issued.

## Timing
- req seen high in IDLE at edge N, then:
  - ACCESS occupies cycles N+1 .. N+WAIT_CYCLES.
  - DONE/ack occupies cycle N+WAIT_CYCLES+1.
  - IDLE returns at cycle N+WAIT_CYCLES+2.
- Read latency from req to ack is WAIT_CYCLES+1 cycles.
- Throughput is one transaction per WAIT_CYCLES+2 cycles.
- All outputs are registered. There are no combinational paths from req to the bus.
- bus_we is high for exactly 1 cycle per write, in cycle N+1.

## Structure
- Shared package io_bus_pkg:
  - state enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - port index constants PORT_CPU=0, PORT_AUX=1;
  - address/data width constants (ADR_W=14, DATA_W=32).
- Sub-module rr_arbiter2:
  - inputs: req[1:0], last;
  - outputs: grant one-hot, winner index;
  - purely combinational, instantiated once.

## Test plan
- Single read: req0=1, we0=0, adr0=14'h3C1C (0xF070), bus_rdata=32'h0000_00A5, WAIT_CYCLES=1 -> gnt0 high in cycle 1, ack0 pulses in cycle 2 with rdata=32'h0000_00A5, bus_we stays 0.
- Single write: req1=1, we1=1, adr1=14'h3C18, wdata1=32'h1234_5678 -> bus_we=1 for exactly 1 cycle carrying that address and data, ack1 pulses 1 cycle later, rdata unchanged.
- Contention after reset: req0 and req1 both held -> grant order port 0, port 1, port 0, port 1. Acks alternate with a period of WAIT_CYCLES+2.
- Wait states: WAIT_CYCLES=3 -> ACCESS lasts 3 cycles, rdata is captured from bus_rdata on the third, ack arrives at N+4.
- Reset mid-ACCESS: rst low in the second ACCESS cycle -> all outputs 0 immediately, no ack. After release, a pending req1 is served first only if req0 is low.
- Request dropped mid-transaction: req0 deasserted in ACCESS -> ack0 still pulses, then a pending req1 is granted next.

Source files
------------

// File: rtl/io_bus_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
// Shared types and constants for the IO bus arbiter slice.
//   bus_state_e : arbiter sequencer states (IDLE, ACCESS, DONE)
//   PORT_CPU    : port index of the CPU data port
//   PORT_AUX    : port index of the secondary master (loader / debug)
//   ADR_W       : bus word-address width (address bits [15:2])
//   DATA_W      : bus data width
//   WCNT_W      : width of the wait-state counter (covers 1..15 cycles)
//   bus_cmd_t   : latched bus command (write enable, address, write data)
//   wait_load() : counter preload for a given number of access cycles
// ---------------------------------------------------------------------------
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned ADR_W  = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WCNT_W = 4;

    typedef struct packed {
        logic              we;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // The counter runs from cycles-1 down to 0, so it is loaded one short.
    function automatic logic [WCNT_W-1:0] wait_load(input int unsigned cycles);
        return WCNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter, purely combinational.
//   req    in  2  request vector, bit i = port i
//   last   in  1  index of the port served most recently
//   grant  out 2  one-hot grant, all zero when nothing is requested
//   winner out 1  index of the granted port (PORT_CPU when idle)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = PORT_CPU;
        case (req)
            2'b01:   winner = PORT_CPU;
            2'b10:   winner = PORT_AUX;
            // Contention: the port that was not served last goes next.
            2'b11:   winner = ~last;
            default: winner = PORT_CPU;
        endcase
    end

    always_comb begin
        grant = '0;
        if (req != 2'b00) begin
            grant = (winner == PORT_AUX) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
// Shares the memory-mapped IO bus between the CPU data port (port 0) and a
// secondary master (port 1). Round-robin on contention, fixed number of bus
// access cycles per transaction, registered outputs throughout.
//   WAIT_CYCLES        param  bus access cycles per transaction (1..15)
//   clk                in   1  clock, rising edge
//   rst                in   1  asynchronous active-low reset
//   req0/req1          in   1  port request, held until that port's ack
//   we0/we1            in   1  port write enable (0 = read)
//   adr0/adr1          in  14  port word address
//   wdata0/wdata1      in  32  port write data
//   gnt0/gnt1          out  1  port owns the bus, first ACCESS cycle to DONE
//   ack0/ack1          out  1  one-cycle completion pulse in DONE
//   rdata              out 32  read data captured on the last ACCESS cycle
//   busy               out  1  sequencer not idle
//   bus_we             out  1  write strobe, first ACCESS cycle of a write
//   bus_adr            out 14  bus word address
//   bus_wdata          out 32  bus write data
//   bus_rdata          in  32  bus read data
// ---------------------------------------------------------------------------
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADR_W-1:0]  adr0,
    input  logic [ADR_W-1:0]  adr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              bus_we,
    output logic [ADR_W-1:0]  bus_adr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_e        state_q,    state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              last_q,     last_d;
    bus_cmd_t          cmd_q,      cmd_d;
    logic              bus_we_q,   bus_we_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [1:0]        gnt_q,      gnt_d;
    logic [1:0]        ack_q,      ack_d;
    logic              busy_q,     busy_d;

    logic [1:0]        arb_grant;
    logic              arb_winner;
    bus_cmd_t          win_cmd;

    rr_arbiter2 u_rr_arbiter2 (
        .req    ({req1, req0}),
        .last   (last_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    always_comb begin
        if (arb_winner == PORT_AUX) begin
            win_cmd = '{we: we1, adr: adr1, wdata: wdata1};
        end else begin
            win_cmd = '{we: we0, adr: adr0, wdata: wdata0};
        end
    end

    // Outputs are computed one state ahead so every output is a flop.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        rdata_d    = rdata_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        bus_we_d   = 1'b0;
        ack_d      = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = ACCESS;
                    cmd_d      = win_cmd;
                    wait_cnt_d = wait_load(WAIT_CYCLES);
                    last_d     = arb_winner;
                    gnt_d      = arb_grant;
                    busy_d     = 1'b1;
                    // Strobe only for the first ACCESS cycle.
                    bus_we_d   = win_cmd.we;
                end
            end

            ACCESS: begin
                if (wait_cnt_q == '0) begin
                    if (!cmd_q.we) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = DONE;
                    ack_d   = gnt_q;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            last_q     <= PORT_AUX;
            cmd_q      <= '0;
            bus_we_q   <= 1'b0;
            rdata_q    <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            bus_we_q   <= bus_we_d;
            rdata_q    <= rdata_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0      = gnt_q[PORT_CPU];
    assign gnt1      = gnt_q[PORT_AUX];
    assign ack0      = ack_q[PORT_CPU];
    assign ack1      = ack_q[PORT_AUX];
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign bus_we    = bus_we_q;
    assign bus_adr   = cmd_q.adr;
    assign bus_wdata = cmd_q.wdata;

endmodule
